// File: rtl/dm_access_ctrl_pkg.sv
// dm_access_ctrl_pkg: shared encodings for the data-memory access controller.
package dm_access_ctrl_pkg;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_BYTE = 2'b01,
        SIZE_HALF = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

    typedef enum logic {PORT_CPU = 1'b0, PORT_DBG = 1'b1} port_e;

    function automatic logic misaligned(size_e size, logic [1:0] lo);
        return size == SIZE_RSVD || (size == SIZE_HALF && lo[0]) || (size == SIZE_WORD && lo != 2'b00);
    endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// dm_access_ctrl_if: CPU, debug and memory-side signals of the data-memory access controller.
interface dm_access_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              cpu_req;
    logic              cpu_we;
    logic [1:0]        cpu_size;
    logic              cpu_sext;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_ack;
    logic [31:0]       cpu_rdata;
    logic              cpu_err;
    logic              dbg_req;
    logic              dbg_we;
    logic [31:0]       dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_ack;
    logic [31:0]       dbg_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_sext, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
        input  cpu_ack, cpu_rdata, cpu_err, dbg_ack, dbg_rdata, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_sext, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
        output cpu_ack, cpu_rdata, cpu_err, dbg_ack, dbg_rdata, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/dm_access_ctrl_lane_merge.sv
// dm_access_ctrl_lane_merge: store lane merge and load lane extract/extend.
module dm_access_ctrl_lane_merge
    import dm_access_ctrl_pkg::*;
(
    input  size_e       size,
    input  logic        sext,
    input  logic [1:0]  lane,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] loaded
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        merged = size == SIZE_WORD ? wdata : rd_word;
        if (size == SIZE_BYTE) merged[8*lane +: 8] = wdata[7:0];
        if (size == SIZE_HALF) merged[16*lane[1] +: 16] = wdata[15:0];
        byte_sel = rd_word[8*lane +: 8];
        half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
        loaded = size == SIZE_BYTE ? {{24{sext & byte_sel[7]}}, byte_sel}
               : size == SIZE_HALF ? {{16{sext & half_sel[15]}}, half_sel}
               : rd_word;
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: round-robin CPU/debug sequencer for the single-port data memory,
// turning sub-word stores into read-modify-write and sub-word loads into extract/extend.
module dm_access_ctrl
    import dm_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic            clk,
    input  logic            reset,
    dm_access_ctrl_if.slave bus
);
    state_e            state_q, state_d;
    port_e             port_q, last_q, grant_port;
    size_e             size_q, req_size;
    logic              we_q, sext_q, err_q;
    logic              req_we, req_err, grant_any, done;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q, rd_word_q, merged, loaded;

    always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;

    always_comb begin
        grant_any  = bus.cpu_req || bus.dbg_req;
        grant_port = (bus.cpu_req && (!bus.dbg_req || last_q == PORT_DBG)) ? PORT_CPU : PORT_DBG;
        req_we     = grant_port == PORT_CPU ? bus.cpu_we : bus.dbg_we;
        req_size   = grant_port == PORT_CPU ? size_e'(bus.cpu_size) : SIZE_WORD;
        req_err    = grant_port == PORT_CPU && misaligned(req_size, bus.cpu_addr[1:0]);
        state_d    = state_q == IDLE ? (!grant_any ? IDLE : req_err ? DONE
                                        : (req_we && req_size == SIZE_WORD) ? WR : RD)
                   : state_q == RD   ? (we_q ? WR : DONE)
                   : state_q == WR   ? DONE
                   : IDLE;
    end

    // Request fields are captured once at grant; the port's live inputs are ignored until its ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q    <= PORT_DBG;
            port_q    <= PORT_CPU;
            we_q      <= 1'b0;
            size_q    <= SIZE_WORD;
            sext_q    <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_word_q <= '0;
        end else begin
            if (state_q == IDLE && grant_any) begin
                last_q  <= grant_port;
                port_q  <= grant_port;
                we_q    <= req_we;
                size_q  <= req_size;
                sext_q  <= grant_port == PORT_CPU && bus.cpu_sext;
                err_q   <= req_err;
                addr_q  <= grant_port == PORT_CPU ? bus.cpu_addr[ADDR_W+1:0]
                                                  : {bus.dbg_addr[ADDR_W+1:2], 2'b00};
                wdata_q <= grant_port == PORT_CPU ? bus.cpu_wdata : bus.dbg_wdata;
            end
            if (state_q == RD) rd_word_q <= bus.mem_rdata;
        end
    end

    dm_access_ctrl_lane_merge u_lane_merge (
        .size    (size_q),
        .sext    (sext_q),
        .lane    (addr_q[1:0]),
        .rd_word (rd_word_q),
        .wdata   (wdata_q),
        .merged  (merged),
        .loaded  (loaded)
    );

    // Reset gates the write strobe and acks so an aborted operation leaves no trace at that edge.
    always_comb begin
        done          = state_q == DONE && !reset;
        bus.cpu_ack   = done && port_q == PORT_CPU;
        bus.dbg_ack   = done && port_q == PORT_DBG;
        bus.cpu_err   = bus.cpu_ack && err_q;
        bus.cpu_rdata = (bus.cpu_ack && !we_q && !err_q) ? loaded : '0;
        bus.dbg_rdata = bus.dbg_ack ? rd_word_q : '0;
        bus.mem_we    = state_q == WR && !reset;
        bus.mem_addr  = addr_q[ADDR_W+1:2];
        bus.mem_wdata = merged;
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: scoreboard bench for dm_access_ctrl against a byte-addressed memory model.
module tb_dm_access_ctrl;
    localparam int ADDR_W = 10;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        chk;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   exp_we = 0;
    int   we_seen = 0;
    int   start_t [2];
    int   mp;
    exp_t me;
    exp_t q [$];

    logic [31:0] mem [1024] = '{default: 32'h0};
    logic [7:0]  rb  [4096] = '{default: 8'h0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    dm_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    function automatic int nbytes(bit [1:0] s);
        return s == 2'd0 ? 4 : s == 2'd1 ? 1 : s == 2'd2 ? 2 : 0;
    endfunction

    function automatic bit misal(bit [1:0] s, bit [31:0] a);
        return s == 2'd3 ? 1'b1 : (int'(a[1:0]) % nbytes(s)) != 0;
    endfunction

    function automatic logic [31:0] mload(bit [1:0] s, bit sx, bit [31:0] a);
        int n = nbytes(s);
        int base = int'(a[11:0]);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rb[base + i];
        if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic mstore(bit [1:0] s, bit [31:0] a, bit [31:0] d);
        int base = int'(a[11:0]);
        for (int i = 0; i < nbytes(s); i++) rb[base + i] = d[8*i +: 8];
        exp_we++;
    endtask

    task automatic cpu_push(bit we, bit [1:0] s, bit sx, bit [31:0] a, bit [31:0] d, bit lat_on);
        exp_t e;
        e.port  = 0;
        e.err   = misal(s, a);
        e.chk   = !we && !e.err;
        e.rdata = e.chk ? mload(s, sx, a) : 32'h0;
        e.lat   = !lat_on ? 0 : e.err ? 2 : (we && s != 2'd0) ? 4 : 3;
        if (we && !e.err) mstore(s, a, d);
        q.push_back(e);
    endtask

    task automatic dbg_push(bit we, bit [31:0] a, bit [31:0] d, bit lat_on);
        exp_t e;
        e.port  = 1;
        e.err   = 1'b0;
        e.chk   = !we;
        e.rdata = we ? 32'h0 : mload(2'd0, 1'b0, a & ~32'h3);
        e.lat   = lat_on ? 3 : 0;
        if (we) mstore(2'd0, a & ~32'h3, d);
        q.push_back(e);
    endtask

    task automatic wait_ack(int p);
        int n;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (p == 1 ? bus.dbg_ack : bus.cpu_ack) break;
        end
        if (n == 40) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: port %0d got no ack within 40 cycles", p);
            summary();
        end
    endtask

    task automatic cpu_drive(bit we, bit [1:0] s, bit sx, bit [31:0] a, bit [31:0] d);
        @(posedge clk);
        #1;
        bus.cpu_we    = we;
        bus.cpu_size  = s;
        bus.cpu_sext  = sx;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_req   = 1'b1;
        start_t[0]    = cyc;
        wait_ack(0);
        bus.cpu_req = 1'b0;
    endtask

    task automatic dbg_drive(bit we, bit [31:0] a, bit [31:0] d);
        @(posedge clk);
        #1;
        bus.dbg_we    = we;
        bus.dbg_addr  = a;
        bus.dbg_wdata = d;
        bus.dbg_req   = 1'b1;
        start_t[1]    = cyc;
        wait_ack(1);
        bus.dbg_req = 1'b0;
    endtask

    task automatic cpu_op(bit we, bit [1:0] s, bit sx, bit [31:0] a, bit [31:0] d);
        cpu_push(we, s, sx, a, d, 1'b1);
        cpu_drive(we, s, sx, a, d);
    endtask

    task automatic dbg_op(bit we, bit [31:0] a, bit [31:0] d);
        dbg_push(we, a, d, 1'b1);
        dbg_drive(we, a, d);
    endtask

    // Monitor: every ack pops the oldest expectation, independent of which driver issued it.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_we) we_seen++;
            if (bus.cpu_ack || bus.dbg_ack) begin
                mp = bus.dbg_ack ? 1 : 0;
                check("ack_overlap", {31'b0, bus.cpu_ack & bus.dbg_ack}, 32'h0);
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack: port %0d acked with no request outstanding", mp);
                end else begin
                    me = q.pop_front();
                    check("grant_port", mp, me.port);
                    if (me.lat != 0) check("latency", cyc - start_t[mp], me.lat - 1);
                    if (mp == 0) begin
                        check("cpu_err", {31'b0, bus.cpu_err}, {31'b0, me.err});
                        if (me.chk) check("cpu_rdata", bus.cpu_rdata, me.rdata);
                        check("dbg_rdata_quiet", bus.dbg_rdata, 32'h0);
                    end else begin
                        check("cpu_err_on_dbg", {31'b0, bus.cpu_err}, 32'h0);
                        if (me.chk) check("dbg_rdata", bus.dbg_rdata, me.rdata);
                        check("cpu_rdata_quiet", bus.cpu_rdata, 32'h0);
                    end
                end
            end
        end
    end

    initial begin
        int          bad;
        bit          we;
        bit [1:0]    s;
        bit [31:0]   a;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_size = 0; bus.cpu_sext = 0;
        bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_cpu_ack", {31'b0, bus.cpu_ack}, 32'h0);
        check("rst_dbg_ack", {31'b0, bus.dbg_ack}, 32'h0);
        check("rst_cpu_err", {31'b0, bus.cpu_err}, 32'h0);
        check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        check("rst_dbg_rdata", bus.dbg_rdata, 32'h0);
        check("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        check("rst_mem_addr", {22'b0, bus.mem_addr}, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        cpu_op(1, 2'd0, 0, 32'h10, 32'h1122_3344);
        dbg_op(0, 32'h10, 0);
        cpu_op(1, 2'd1, 0, 32'h13, 32'h0000_00AA);
        dbg_op(0, 32'h12, 0);
        cpu_op(0, 2'd1, 1, 32'h13, 0);
        cpu_op(0, 2'd1, 0, 32'h13, 0);
        cpu_op(0, 2'd2, 1, 32'h10, 0);
        cpu_op(1, 2'd2, 0, 32'h12, 32'h0000_BEEF);
        dbg_op(0, 32'h10, 0);
        cpu_op(0, 2'd0, 0, 32'h11, 0);
        cpu_op(1, 2'd2, 0, 32'h13, 32'h0000_1234);
        cpu_op(1, 2'd3, 0, 32'h10, 32'hDEAD_BEEF);
        dbg_op(0, 32'h10, 0);
        // Fresh reset so the first tie goes to the CPU.
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        cpu_push(0, 2'd0, 0, 32'h10, 0, 1'b0);
        dbg_push(1, 32'h20, 32'hCAFE_0001, 1'b0);
        cpu_push(1, 2'd0, 0, 32'h24, 32'h5A5A_1234, 1'b0);
        dbg_push(0, 32'h24, 0, 1'b0);
        fork
            begin
                cpu_drive(0, 2'd0, 0, 32'h10, 0);
                cpu_drive(1, 2'd0, 0, 32'h24, 32'h5A5A_1234);
            end
            begin
                dbg_drive(1, 32'h20, 32'hCAFE_0001);
                dbg_drive(0, 32'h24, 0);
            end
        join
        for (int i = 0; i < 250; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 2) == 0) begin
                dbg_op(we, a, $urandom);
            end else begin
                s = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
                if ($urandom_range(0, 3) != 0) a = s == 2'd0 ? a & ~32'h3 : s == 2'd2 ? a & ~32'h1 : a;
                cpu_op(we, s, 1'($urandom_range(0, 1)), a, $urandom);
            end
        end
        // Abort a byte store while it sits in WR: nothing may be written or acked.
        @(posedge clk);
        #1;
        bus.cpu_we = 1; bus.cpu_size = 2'd1; bus.cpu_sext = 0;
        bus.cpu_addr = 32'h21; bus.cpu_wdata = 32'h0000_0055; bus.cpu_req = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("abort_in_wr", {31'b0, bus.mem_we}, 32'h1);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        #1;
        check("abort_we_gated", {31'b0, bus.mem_we}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        dbg_op(0, 32'h20, 0);
        repeat (5) @(posedge clk);
        check("scoreboard_drain", q.size(), 32'h0);
        check("mem_we_count", we_seen, exp_we);
        bad = 0;
        for (int w = 0; w < 1024; w++)
            if (mem[w] !== {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]}) bad++;
        check("mem_contents_bad_words", bad, 32'h0);
        summary();
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
